// File: rtl/fb_pkg.sv
// Shared framebuffer definitions: geometry, arbiter state encoding and the
// {y, x} address packing used by the write port.
package fb_pkg;

  localparam int FB_COORD_W = 8;
  localparam int FB_DATA_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fb_state_t;

  function automatic logic [31:0] fb_addr(input logic [31:0] x,
                                          input logic [31:0] y,
                                          input int unsigned cw = FB_COORD_W);
    return (y << cw) | x;
  endfunction

endpackage

// File: rtl/fb_rect_walker.sv
// Rectangle walker: steps a pixel cursor row by row over a latched rectangle,
// wrapping coordinates modulo 2^COORD_W while counting columns/rows separately.
module fb_rect_walker import fb_pkg::*; #(
  parameter int COORD_W = FB_COORD_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W:0]   w,
  input  logic [COORD_W:0]   h,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               last
);

  logic [COORD_W-1:0] x0_q;
  logic [COORD_W-1:0] cur_x;
  logic [COORD_W-1:0] cur_y;
  logic [COORD_W:0]   w_q;
  logic [COORD_W:0]   h_q;
  logic [COORD_W:0]   col_cnt;
  logic [COORD_W:0]   row_cnt;
  logic               row_end;

  // Counters are one bit wider than coordinates so a full-width row ends on count 2^COORD_W-1.
  assign row_end = (col_cnt == w_q - 1'b1);
  assign last    = row_end && (row_cnt == h_q - 1'b1);
  assign pix_x   = cur_x;
  assign pix_y   = cur_y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x0_q    <= '0;
      w_q     <= '0;
      h_q     <= '0;
      cur_x   <= '0;
      cur_y   <= '0;
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (load) begin
      x0_q    <= x0;
      w_q     <= w;
      h_q     <= h;
      cur_x   <= x0;
      cur_y   <= y0;
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (step) begin
      if (row_end) begin
        cur_x   <= x0_q;
        col_cnt <= '0;
        cur_y   <= cur_y + 1'b1;
        row_cnt <= row_cnt + 1'b1;
      end else begin
        cur_x   <= cur_x + 1'b1;
        col_cnt <= col_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Framebuffer write-port controller: shares one RAM write port between CPU pixel
// stores and a rectangle-fill engine, alternating owners while a fill runs.
//
// Handshake: a CPU write is accepted on any rising clk edge where cpu_valid and
// cpu_ready are both high; cpu_ready is combinational and may depend on cpu_valid,
// cpu_valid must not depend on cpu_ready. Accepted writes appear on fb_* one cycle later.
module fb_write_arbiter import fb_pkg::*; #(
  parameter int DATA_WIDTH = FB_DATA_W,
  parameter int COORD_W    = FB_COORD_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_valid,
  input  logic [COORD_W-1:0]    cpu_x,
  input  logic [COORD_W-1:0]    cpu_y,
  input  logic [DATA_WIDTH-1:0] cpu_data,
  output logic                  cpu_ready,
  input  logic                  fill_start,
  input  logic [COORD_W-1:0]    fill_x0,
  input  logic [COORD_W-1:0]    fill_y0,
  input  logic [COORD_W:0]      fill_w,
  input  logic [COORD_W:0]      fill_h,
  input  logic [DATA_WIDTH-1:0] fill_color,
  output logic                  fill_busy,
  output logic                  fill_done,
  output logic                  fb_we,
  output logic [31:0]           fb_addr,
  output logic [DATA_WIDTH-1:0] fb_wd,
  output logic [1:0]            dbg_state
);

  fb_state_t             state;
  fb_state_t             state_nxt;
  logic                  last_fill;
  logic                  load;
  logic                  fill_wr;
  logic                  cpu_wr;
  logic                  zero_size;
  logic                  walk_last;
  logic [COORD_W-1:0]    pix_x;
  logic [COORD_W-1:0]    pix_y;
  logic [DATA_WIDTH-1:0] color_q;

  fb_rect_walker #(.COORD_W(COORD_W)) u_walker (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .step  (fill_wr),
    .x0    (fill_x0),
    .y0    (fill_y0),
    .w     (fill_w),
    .h     (fill_h),
    .pix_x (pix_x),
    .pix_y (pix_y),
    .last  (walk_last)
  );

  assign zero_size = (fill_w == '0) || (fill_h == '0);
  assign cpu_wr    = cpu_valid && cpu_ready;
  assign fill_busy = (state != IDLE);
  assign fill_done = (state == DONE);
  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    cpu_ready = 1'b0;
    fill_wr   = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        cpu_ready = 1'b1;
        if (fill_start) begin
          load      = 1'b1;
          state_nxt = zero_size ? DONE : FILL;
        end
      end
      FILL: begin
        // The CPU only wins if the fill had the previous FILL-cycle grant.
        cpu_ready = cpu_valid && last_fill;
        fill_wr   = !cpu_ready;
        if (fill_wr && walk_last) state_nxt = DONE;
      end
      DONE: begin
        cpu_ready = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last_fill <= 1'b0;
      color_q   <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        last_fill <= 1'b0;
        color_q   <= fill_color;
      end else if (state == FILL) begin
        last_fill <= fill_wr;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_we   <= 1'b0;
      fb_addr <= '0;
      fb_wd   <= '0;
    end else begin
      fb_we <= cpu_wr || fill_wr;
      if (fill_wr) begin
        fb_addr <= fb_pkg::fb_addr(32'(pix_x), 32'(pix_y), COORD_W);
        fb_wd   <= color_q;
      end else if (cpu_wr) begin
        fb_addr <= fb_pkg::fb_addr(32'(cpu_x), 32'(cpu_y), COORD_W);
        fb_wd   <= cpu_data;
      end
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter: hand-computed write sequences checked in
// order against an expected queue, plus handshake, busy/done and reset checks.
module tb_fb_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_valid;
  logic [7:0]  cpu_x;
  logic [7:0]  cpu_y;
  logic [7:0]  cpu_data;
  logic        cpu_ready;
  logic        fill_start;
  logic [7:0]  fill_x0;
  logic [7:0]  fill_y0;
  logic [8:0]  fill_w;
  logic [8:0]  fill_h;
  logic [7:0]  fill_color;
  logic        fill_busy;
  logic        fill_done;
  logic        fb_we;
  logic [31:0] fb_addr;
  logic [7:0]  fb_wd;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  int wr_cnt = 0;
  logic [39:0] exp_q[$];

  fb_write_arbiter #(.DATA_WIDTH(8), .COORD_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_valid  (cpu_valid),
    .cpu_x      (cpu_x),
    .cpu_y      (cpu_y),
    .cpu_data   (cpu_data),
    .cpu_ready  (cpu_ready),
    .fill_start (fill_start),
    .fill_x0    (fill_x0),
    .fill_y0    (fill_y0),
    .fill_w     (fill_w),
    .fill_h     (fill_h),
    .fill_color (fill_color),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done),
    .fb_we      (fb_we),
    .fb_addr    (fb_addr),
    .fb_wd      (fb_wd),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // scoreboard: every RAM write must match the head of exp_q, in order
  always @(negedge clk) begin
    if (!rst) begin
      if (fb_we) begin
        wr_cnt++;
        if (exp_q.size() == 0) check("unexpected_write", 40'(fb_we), 40'd0);
        else check("write", {fb_wd, fb_addr}, exp_q.pop_front());
      end
      if (fill_busy) busy_cnt++;
      if (fill_done) done_cnt++;
    end
  end

  // driver tasks
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    busy_cnt = 0;
    done_cnt = 0;
    wr_cnt   = 0;
  endtask

  task automatic push_wr(input logic [7:0] x, input logic [7:0] y, input logic [7:0] d);
    exp_q.push_back({d, 16'h0000, y, x});
  endtask

  task automatic start_fill(input logic [7:0] x0, input logic [7:0] y0,
                            input logic [8:0] w, input logic [8:0] h, input logic [7:0] c);
    fill_x0    = x0;
    fill_y0    = y0;
    fill_w     = w;
    fill_h     = h;
    fill_color = c;
    fill_start = 1'b1;
    @(negedge clk);
    check("busy_on_start_cycle", 40'(fill_busy), 40'd0);
    nxt();
    fill_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (fill_done) break;
    end
    check({tag, "_done_timeout"}, 40'(i >= budget), 40'd0);
    nxt();
  endtask

  initial begin
    rst        = 1'b1;
    cpu_valid  = 1'b0;
    cpu_x      = '0;
    cpu_y      = '0;
    cpu_data   = '0;
    fill_start = 1'b0;
    fill_x0    = '0;
    fill_y0    = '0;
    fill_w     = '0;
    fill_h     = '0;
    fill_color = '0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_we",    40'(fb_we), 40'd0);
    check("rst_addr",  40'(fb_addr), 40'd0);
    check("rst_wd",    40'(fb_wd), 40'd0);
    check("rst_busy",  40'(fill_busy), 40'd0);
    check("rst_done",  40'(fill_done), 40'd0);
    check("rst_state", 40'(dbg_state), 40'd0);
    check("rst_ready", 40'(cpu_ready), 40'd1);
    nxt();
    rst = 1'b0;
    nxt();

    // CPU-only write
    push_wr(8'h03, 8'h02, 8'hAB);
    cpu_valid = 1'b1; cpu_x = 8'h03; cpu_y = 8'h02; cpu_data = 8'hAB;
    @(negedge clk);
    check("cpu_ready_idle", 40'(cpu_ready), 40'd1);
    nxt();
    cpu_valid = 1'b0;
    @(negedge clk);
    check("cpu_we", 40'(fb_we), 40'd1);
    nxt();
    nxt();
    check("cpu_drain", 40'(exp_q.size()), 40'd0);

    // wrapping fill
    clear_counts();
    push_wr(8'hFE, 8'hFF, 8'h55); push_wr(8'hFF, 8'hFF, 8'h55); push_wr(8'h00, 8'hFF, 8'h55);
    push_wr(8'hFE, 8'h00, 8'h55); push_wr(8'hFF, 8'h00, 8'h55); push_wr(8'h00, 8'h00, 8'h55);
    start_fill(8'd254, 8'd255, 9'd3, 9'd2, 8'h55);
    @(negedge clk);
    check("wrap_busy_rise", 40'(fill_busy), 40'd1);
    wait_done("wrap", 30);
    nxt();
    check("wrap_busy_cycles", 40'(busy_cnt), 40'd7);
    check("wrap_done_pulses", 40'(done_cnt), 40'd1);
    check("wrap_drain", 40'(exp_q.size()), 40'd0);

    // contention: 2x2 fill against a CPU that keeps requesting
    begin
      int k;
      bit first;
      clear_counts();
      push_wr(8'h10, 8'h20, 8'h77); push_wr(8'h00, 8'h40, 8'hC0);
      push_wr(8'h11, 8'h20, 8'h77); push_wr(8'h01, 8'h40, 8'hC1);
      push_wr(8'h10, 8'h21, 8'h77); push_wr(8'h02, 8'h40, 8'hC2);
      push_wr(8'h11, 8'h21, 8'h77); push_wr(8'h03, 8'h40, 8'hC3);
      start_fill(8'h10, 8'h20, 9'd2, 9'd2, 8'h77);
      k = 0;
      first = 1'b1;
      cpu_valid = 1'b1; cpu_y = 8'h40; cpu_x = 8'h00; cpu_data = 8'hC0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (first) check("ctn_fill_first", 40'(cpu_ready), 40'd0);
        first = 1'b0;
        if (cpu_ready) k++;
        nxt();
        if (k == 4) break;
        cpu_x = 8'(k); cpu_data = 8'hC0 + 8'(k);
      end
      cpu_valid = 1'b0;
      nxt();
      nxt();
      check("ctn_cpu_accepts", 40'(k), 40'd4);
      check("ctn_busy_cycles", 40'(busy_cnt), 40'd8);
      check("ctn_done_pulses", 40'(done_cnt), 40'd1);
      check("ctn_writes", 40'(wr_cnt), 40'd8);
      check("ctn_drain", 40'(exp_q.size()), 40'd0);
    end

    // fill_start during FILL is ignored
    clear_counts();
    push_wr(8'h30, 8'h31, 8'h11); push_wr(8'h31, 8'h31, 8'h11); push_wr(8'h32, 8'h31, 8'h11);
    start_fill(8'h30, 8'h31, 9'd3, 9'd1, 8'h11);
    fill_x0 = 8'h00; fill_y0 = 8'h00; fill_w = 9'd1; fill_h = 9'd1; fill_color = 8'hEE;
    fill_start = 1'b1;
    nxt();
    fill_start = 1'b0;
    wait_done("ignore", 20);
    repeat (3) nxt();
    check("ignore_busy_cycles", 40'(busy_cnt), 40'd4);
    check("ignore_writes", 40'(wr_cnt), 40'd3);
    check("ignore_drain", 40'(exp_q.size()), 40'd0);

    // zero-size fill
    clear_counts();
    start_fill(8'h12, 8'h34, 9'd0, 9'd5, 8'hAA);
    @(negedge clk);
    check("zero_busy", 40'(fill_busy), 40'd1);
    check("zero_done", 40'(fill_done), 40'd1);
    check("zero_state", 40'(dbg_state), 40'd2);
    nxt();
    @(negedge clk);
    check("zero_busy_fall", 40'(fill_busy), 40'd0);
    nxt();
    check("zero_busy_cycles", 40'(busy_cnt), 40'd1);
    check("zero_done_pulses", 40'(done_cnt), 40'd1);
    check("zero_writes", 40'(wr_cnt), 40'd0);

    // reset in the middle of a 4x4 fill, after 5 writes
    begin
      int i;
      clear_counts();
      push_wr(8'h50, 8'h60, 8'h99); push_wr(8'h51, 8'h60, 8'h99); push_wr(8'h52, 8'h60, 8'h99);
      push_wr(8'h53, 8'h60, 8'h99); push_wr(8'h50, 8'h61, 8'h99);
      start_fill(8'h50, 8'h60, 9'd4, 9'd4, 8'h99);
      for (i = 0; i < 20; i++) begin
        @(negedge clk);
        #1;
        if (wr_cnt == 5) break;
      end
      check("rmid_wait_timeout", 40'(i >= 20), 40'd0);
      rst = 1'b1;
      #1;
      check("rmid_we",   40'(fb_we), 40'd0);
      check("rmid_addr", 40'(fb_addr), 40'd0);
      check("rmid_wd",   40'(fb_wd), 40'd0);
      check("rmid_busy", 40'(fill_busy), 40'd0);
      check("rmid_done", 40'(fill_done), 40'd0);
      nxt();
      nxt();
      rst = 1'b0;
      @(negedge clk);
      check("rmid_state", 40'(dbg_state), 40'd0);
      check("rmid_ready", 40'(cpu_ready), 40'd1);
      nxt();
      nxt();
      check("rmid_done_pulses", 40'(done_cnt), 40'd0);
      check("rmid_writes", 40'(wr_cnt), 40'd5);
      check("rmid_drain", 40'(exp_q.size()), 40'd0);
    end

    // full-width row: x0=10, w=256 wraps to column 9, each column once
    clear_counts();
    for (int i = 0; i < 256; i++) push_wr(8'(10 + i), 8'h07, 8'h3C);
    start_fill(8'd10, 8'h07, 9'd256, 9'd1, 8'h3C);
    wait_done("row", 400);
    nxt();
    check("row_busy_cycles", 40'(busy_cnt), 40'd257);
    check("row_done_pulses", 40'(done_cnt), 40'd1);
    check("row_writes", 40'(wr_cnt), 40'd256);
    check("row_drain", 40'(exp_q.size()), 40'd0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
